// File: rtl/mem_arb_pkg.sv
// Shared types, default address window and helper for the RAM port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  localparam logic [31:0] DEF_BASE_ADDR  = 32'hBFC00000;
  localparam logic [31:0] DEF_SIZE_BYTES = 32'h00400000;

  // Wide enough for the largest legal MAX_CONSEC (15).
  localparam int CNT_W = 4;

  // Window hit by wrap-around subtraction: an address below the base wraps
  // to a huge offset and therefore misses.
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] size);
    return (addr - base) < size;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the instruction and data ports, with a counter
// that bounds how long a waiting instruction fetch can be passed over.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_CONSEC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  output logic i_gnt,
  output logic d_gnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CONSEC);

  logic [CNT_W-1:0] consec_cnt_reg;
  logic             i_starved;

  assign i_starved = (consec_cnt_reg == MAX_CNT);

  // Data has priority unless the instruction port has already been passed over MAX_CONSEC times.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (arb_en) begin
      if (d_req && !(i_req && i_starved)) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  // Count data grants taken while an instruction fetch waits; saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      consec_cnt_reg <= '0;
    end else if (i_gnt || !i_req) begin
      consec_cnt_reg <= '0;
    end else if (d_gnt && !i_starved) begin
      consec_cnt_reg <= consec_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-enabled 32-bit RAM between the instruction-fetch and data
// ports: arbitrates, registers the winning request onto the RAM port, checks
// the address window and returns a one-cycle response two cycles after grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter logic [31:0] SIZE_BYTES = DEF_SIZE_BYTES,
  parameter int          MAX_CONSEC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] ram_a,
  output logic        ram_we,
  output logic [31:0] ram_wd,
  output logic [3:0]  ram_be,
  input  logic [31:0] ram_rd
);

  state_t      state_reg;
  state_t      state_next;
  port_t       port_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        we_reg;
  logic [3:0]  be_reg;

  logic        arb_en;
  logic        any_gnt;
  logic        in_win;
  logic        issue;
  logic        resp;
  logic [31:0] resp_data;

  // Grants are only offered when the RAM port is free for a new request, and
  // never while reset is asserted (such a grant would be discarded).
  assign arb_en  = rst_n && ((state_reg == IDLE) || (state_reg == RESP));
  assign any_gnt = i_gnt | d_gnt;

  mem_arb_pick #(
    .MAX_CONSEC (MAX_CONSEC)
  ) u_pick (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_en (arb_en),
    .i_req  (i_req),
    .d_req  (d_req),
    .i_gnt  (i_gnt),
    .d_gnt  (d_gnt)
  );

  // Sequencing: a grant always leads to ISSUE, ISSUE to RESP; RESP may regrant.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = any_gnt ? ISSUE : IDLE;
      ISSUE:   state_next = RESP;
      RESP:    state_next = any_gnt ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and capture of the winning request on the grant edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      port_reg  <= PORT_I;
      addr_reg  <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      be_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (i_gnt) begin
        port_reg  <= PORT_I;
        addr_reg  <= i_addr;
        wdata_reg <= '0;
        we_reg    <= 1'b0;
        be_reg    <= 4'b1111;
      end else if (d_gnt) begin
        port_reg  <= PORT_D;
        addr_reg  <= d_addr;
        wdata_reg <= d_wdata;
        we_reg    <= d_we;
        be_reg    <= d_be;
      end
    end
  end

  assign in_win = addr_in_window(addr_reg, BASE_ADDR, SIZE_BYTES);
  assign issue  = (state_reg == ISSUE);
  assign resp   = (state_reg == RESP);

  // RAM side: the address simply holds between accesses; strobes only in ISSUE
  // and only for in-window accesses.
  assign ram_a  = addr_reg;
  assign ram_wd = wdata_reg;
  assign ram_we = issue && we_reg && in_win;
  assign ram_be = (issue && in_win) ? be_reg : 4'b0000;

  // Response routing: writes and out-of-window accesses return zero data.
  always_comb begin
    resp_data = (in_win && !we_reg) ? ram_rd : 32'h0;
    i_rvalid  = resp && (port_reg == PORT_I);
    d_rvalid  = resp && (port_reg == PORT_D);
    i_err     = i_rvalid && !in_win;
    d_err     = d_rvalid && !in_win;
    i_rdata   = i_rvalid ? resp_data : 32'h0;
    d_rdata   = d_rvalid ? resp_data : 32'h0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam logic [31:0] SIZE = 32'h00400000;
  localparam int          MAXC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_we;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [31:0] ram_a, ram_wd, ram_rd;
  logic        ram_we;
  logic [3:0]  ram_be;

  int tests = 0;
  int fails = 0;

  // RAM contents (driven by the DUT) and the expected memory image.
  logic [31:0] ram_mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        load;

  typedef struct {
    int          due;
    bit          is_d;
    logic [31:0] data;
    bit          err;
  } resp_t;

  mem_port_arbiter #(
    .BASE_ADDR  (BASE),
    .SIZE_BYTES (SIZE),
    .MAX_CONSEC (MAXC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .i_err    (i_err),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_we     (d_we),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .ram_a    (ram_a),
    .ram_we   (ram_we),
    .ram_wd   (ram_wd),
    .ram_be   (ram_be),
    .ram_rd   (ram_rd)
  );

  always #5 clk = ~clk;

  // Registered-read RAM with byte-enabled synchronous write (4 KB, aliased).
  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < 1024; k++) ram_mem[k] <= ref_mem[k];
    end else if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) ram_mem[ram_a[11:2]][8*b +: 8] <= ram_wd[8*b +: 8];
    end
    ram_rd <= ram_mem[ram_a[11:2]];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_window(input logic [31:0] a);
    logic [32:0] a33, lo, hi;
    a33 = {1'b0, a};
    lo  = {1'b0, BASE};
    hi  = {1'b0, BASE} + {1'b0, SIZE};
    return (a33 >= lo) && (a33 < hi);
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    case (r)
      0:       a = BASE - 32'd4;
      1:       a = BASE + SIZE;
      2:       a = $urandom & 32'hFFFF_FFFC;
      default: a = BASE + 32'(4 * $urandom_range(0, 31));
    endcase
    return a;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if ({i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, ram_we} !== 7'b0) begin
        fails++;
        $display("FAIL reset.flags cyc=%0d got=%b want=0000000", c,
                 {i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, ram_we});
      end
      tests++;
      if ({ram_a, ram_wd, i_rdata, d_rdata, ram_be} !== 132'b0) begin
        fails++;
        $display("FAIL reset.data cyc=%0d ram_a=%h ram_wd=%h i_rdata=%h d_rdata=%h ram_be=%b want all 0",
                 c, ram_a, ram_wd, i_rdata, d_rdata, ram_be);
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_read;
    d_req = 1'b1; d_addr = BASE + 32'h10; d_we = 1'b0; d_be = 4'hF; d_wdata = $urandom;
    @(negedge clk);
    tests++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
      fails++; $display("FAIL single_read.gnt got d=%b i=%b want d=1 i=0", d_gnt, i_gnt);
    end
    tick();
    d_req = 1'b0;
    @(negedge clk);
    tests++;
    if (ram_a !== 32'hBFC00010) begin
      fails++; $display("FAIL single_read.ram_a got=%h want=bfc00010", ram_a);
    end
    tests++;
    if (d_rvalid !== 1'b0) begin
      fails++; $display("FAIL single_read.early_rvalid got=%b want=0", d_rvalid);
    end
    tick();
    @(negedge clk);
    tests++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h11223344 || d_err !== 1'b0) begin
      fails++;
      $display("FAIL single_read.resp got rvalid=%b rdata=%h err=%b want 1/11223344/0",
               d_rvalid, d_rdata, d_err);
    end
    tick();
  endtask

  task automatic test_write_read;
    int pulses = 0;
    d_req = 1'b1; d_addr = BASE + 32'h20; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'hAABBCCDD;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ram_we === 1'b1) pulses++;
      if (c == 1) begin
        tests++;
        if (ram_be !== 4'b0011 || ram_wd !== 32'hAABBCCDD) begin
          fails++; $display("FAIL write.ram_be got be=%b wd=%h want 0011/aabbccdd", ram_be, ram_wd);
        end
      end
      if (c == 2) begin
        tests++;
        if (d_rvalid !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'h0) begin
          fails++; $display("FAIL write.resp got rvalid=%b err=%b rdata=%h want 1/0/0", d_rvalid, d_err, d_rdata);
        end
      end
      tick();
      d_req = 1'b0;
    end
    tests++;
    if (pulses != 1) begin
      fails++; $display("FAIL write.we_pulses got=%0d want=1", pulses);
    end
    ref_mem[8] = 32'h0000CCDD;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF;
    @(negedge clk);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    tests++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h0000CCDD) begin
      fails++; $display("FAIL write.readback got rvalid=%b rdata=%h want 1/0000ccdd", d_rvalid, d_rdata);
    end
    tick();
  endtask

  task automatic test_contention;
    bit exp_i, exp_d, rv_i, rv_d;
    int g;
    i_req = 1'b1; i_addr = BASE + 32'h40;
    d_req = 1'b1; d_addr = BASE + 32'h44; d_we = 1'b0; d_be = 4'hF;
    for (int c = 0; c < 20; c++) begin
      exp_i = 1'b0; exp_d = 1'b0; rv_i = 1'b0; rv_d = 1'b0;
      if (c % 2 == 0) begin
        g = c / 2;
        if (g % 5 == 4) exp_i = 1'b1; else exp_d = 1'b1;
        if (c >= 2) begin
          g = (c - 2) / 2;
          if (g % 5 == 4) rv_i = 1'b1; else rv_d = 1'b1;
        end
      end
      @(negedge clk);
      tests++;
      if (i_gnt !== exp_i || d_gnt !== exp_d) begin
        fails++; $display("FAIL contention.gnt cyc=%0d got i=%b d=%b want i=%b d=%b", c, i_gnt, d_gnt, exp_i, exp_d);
      end
      tests++;
      if (i_rvalid !== rv_i || d_rvalid !== rv_d) begin
        fails++; $display("FAIL contention.rvalid cyc=%0d got i=%b d=%b want i=%b d=%b", c, i_rvalid, d_rvalid, rv_i, rv_d);
      end
      if (rv_i) begin
        tests++;
        if (i_rdata !== ref_mem[16]) begin
          fails++; $display("FAIL contention.i_rdata cyc=%0d got=%h want=%h", c, i_rdata, ref_mem[16]);
        end
      end
      if (rv_d) begin
        tests++;
        if (d_rdata !== ref_mem[17]) begin
          fails++; $display("FAIL contention.d_rdata cyc=%0d got=%h want=%h", c, d_rdata, ref_mem[17]);
        end
      end
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_out_of_window;
    int strobes = 0;
    i_req = 1'b1; i_addr = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ram_we !== 1'b0 || ram_be !== 4'b0) strobes++;
      if (c == 2) begin
        tests++;
        if (i_rvalid !== 1'b1 || i_err !== 1'b1 || i_rdata !== 32'h0) begin
          fails++; $display("FAIL oow.i_resp got rvalid=%b err=%b rdata=%h want 1/1/0", i_rvalid, i_err, i_rdata);
        end
      end
      tick();
      i_req = 1'b0;
    end
    for (int t = 0; t < 2; t++) begin
      d_req = 1'b1; d_addr = BASE + SIZE; d_we = (t == 0); d_be = 4'hF; d_wdata = 32'h12345678;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (ram_we !== 1'b0 || ram_be !== 4'b0) strobes++;
        if (c == 2) begin
          tests++;
          if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0) begin
            fails++; $display("FAIL oow.d_resp op=%0d got rvalid=%b err=%b rdata=%h want 1/1/0", t, d_rvalid, d_err, d_rdata);
          end
        end
        tick();
        d_req = 1'b0;
      end
    end
    tests++;
    if (strobes != 0) begin
      fails++; $display("FAIL oow.strobes got=%0d cycles with ram_we/ram_be set want=0", strobes);
    end
  endtask

  task automatic test_reset_mid;
    d_req = 1'b1; d_addr = BASE + 32'h10; d_we = 1'b0; d_be = 4'hF;
    @(negedge clk);
    tests++;
    if (d_gnt !== 1'b1) begin
      fails++; $display("FAIL reset_mid.gnt got=%b want=1", d_gnt);
    end
    tick();
    d_req = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if ({i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, ram_we} !== 7'b0 ||
          ram_a !== 32'h0 || ram_be !== 4'b0 || d_rdata !== 32'h0) begin
        fails++;
        $display("FAIL reset_mid.quiet cyc=%0d flags=%b ram_a=%h ram_be=%b d_rdata=%h want all 0", c,
                 {i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, ram_we}, ram_a, ram_be, d_rdata);
      end
      tick();
    end
    d_req = 1'b1;
    @(negedge clk);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    tests++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h11223344) begin
      fails++; $display("FAIL reset_mid.after got rvalid=%b rdata=%h want 1/11223344", d_rvalid, d_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    localparam int N = 6;
    int k = 0;
    bit exp_g, exp_rv;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = BASE + 32'h100;
    for (int c = 0; c <= 2 * N; c++) begin
      exp_g  = (c % 2 == 0) && (c / 2 < N);
      exp_rv = (c >= 2) && (c % 2 == 0);
      @(negedge clk);
      tests++;
      if (d_gnt !== exp_g || d_rvalid !== exp_rv) begin
        fails++; $display("FAIL b2b.hs cyc=%0d got gnt=%b rvalid=%b want gnt=%b rvalid=%b", c, d_gnt, d_rvalid, exp_g, exp_rv);
      end
      if (exp_rv) begin
        tests++;
        if (d_rdata !== ref_mem[64 + c / 2 - 1]) begin
          fails++; $display("FAIL b2b.rdata cyc=%0d got=%h want=%h", c, d_rdata, ref_mem[64 + c / 2 - 1]);
        end
      end
      tick();
      if (exp_g) begin
        k++;
        if (k < N) d_addr = BASE + 32'h100 + 32'(4 * k);
        else d_req = 1'b0;
      end
    end
  endtask

  task automatic test_random;
    resp_t       pend[$];
    resp_t       r;
    resp_t       nr;
    int          free_at = 0;
    int          consec = 0;
    int          we_at = -1;
    logic [3:0]  we_be = 4'b0;
    bit          exp_i, exp_d, have, g_we, g_in;
    logic [31:0] g_addr;
    logic [9:0]  idx;
    for (int c = 0; c < 406; c++) begin
      if (c < 400) begin
        i_req = ($urandom_range(0, 3) != 0); i_addr = rand_addr();
        d_req = ($urandom_range(0, 3) != 0); d_addr = rand_addr();
        d_we = $urandom_range(0, 1); d_wdata = $urandom; d_be = 4'($urandom_range(0, 15));
      end else begin
        i_req = 1'b0; d_req = 1'b0;
      end
      exp_i = 1'b0; exp_d = 1'b0;
      if (c >= free_at) begin
        if (d_req && !(i_req && consec >= MAXC)) exp_d = 1'b1;
        else if (i_req) exp_i = 1'b1;
      end
      have = (pend.size() > 0) && (pend[0].due == c);
      if (have) r = pend.pop_front();
      @(negedge clk);
      tests++;
      if (i_gnt !== exp_i || d_gnt !== exp_d) begin
        fails++; $display("FAIL random.gnt cyc=%0d got i=%b d=%b want i=%b d=%b", c, i_gnt, d_gnt, exp_i, exp_d);
      end
      tests++;
      if (i_rvalid !== (have && !r.is_d) || d_rvalid !== (have && r.is_d)) begin
        fails++; $display("FAIL random.rvalid cyc=%0d got i=%b d=%b want i=%b d=%b", c, i_rvalid, d_rvalid,
                          have && !r.is_d, have && r.is_d);
      end
      if (have) begin
        tests++;
        if (r.is_d ? (d_rdata !== r.data || d_err !== r.err) : (i_rdata !== r.data || i_err !== r.err)) begin
          fails++; $display("FAIL random.resp cyc=%0d port=%s got rdata=%h err=%b want rdata=%h err=%b", c,
                            r.is_d ? "d" : "i", r.is_d ? d_rdata : i_rdata, r.is_d ? d_err : i_err, r.data, r.err);
        end
      end
      tests++;
      if (ram_we !== (c == we_at) || ((c == we_at) && ram_be !== we_be)) begin
        fails++; $display("FAIL random.ram_we cyc=%0d got we=%b be=%b want we=%b be=%b", c, ram_we, ram_be, c == we_at, we_be);
      end
      if (exp_i || exp_d) begin
        g_addr = exp_i ? i_addr : d_addr;
        g_we   = exp_d && d_we;
        g_in   = in_window(g_addr);
        idx    = g_addr[11:2];
        nr.due  = c + 2;
        nr.is_d = exp_d;
        nr.err  = !g_in;
        nr.data = (g_in && !g_we) ? ref_mem[idx] : 32'h0;
        if (g_we && g_in) begin
          for (int b = 0; b < 4; b++)
            if (d_be[b]) ref_mem[idx][8*b +: 8] = d_wdata[8*b +: 8];
          we_at = c + 1;
          we_be = d_be;
        end
        pend.push_back(nr);
        free_at = c + 2;
      end
      if (exp_i || !i_req) consec = 0;
      else if (exp_d && consec < MAXC) consec++;
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_addr = 32'h0; d_we = 1'b0; d_wdata = 32'h0; d_be = 4'h0;
    for (int k = 0; k < 1024; k++) ref_mem[k] = $urandom;
    ref_mem[0] = 32'hDEADBEEF;
    ref_mem[4] = 32'h11223344;
    ref_mem[8] = 32'h0;
    tick();
    load = 1'b0;
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_out_of_window();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
